// File: rtl/ssd1306_spi_byte_tx_if.sv
// Byte handshake between the SSD1306 sequencer and its SPI transmit stage.
// The master offers {tx_dc, tx_data} with tx_valid. The slave accepts it by asserting tx_ready.
interface ssd1306_spi_byte_tx_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_dc;

  modport master (output tx_valid, output tx_data, output tx_dc, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_dc, output tx_ready);
endinterface

// File: rtl/ssd1306_spi_byte_tx.sv
// SPI mode-0, MSB-first byte transmitter for the SSD1306, fed through a small D/C-tagged FIFO.
// Pin outputs are registered, so they trail the FSM state by one cycle.
module ssd1306_spi_byte_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_HOLD    = 2
) (
  input  logic                              clk_50M,
  input  logic                              rst,
  ssd1306_spi_byte_tx_if.slave              tx,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              busy,
  output logic                              done,
  output logic                              oled_sclk,
  output logic                              oled_sdin,
  output logic                              oled_dc,
  output logic                              ss
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam int HLD_W = $clog2(CS_HOLD + 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  // ---------------- FIFO ----------------
  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             full, empty, push, pop;

  state_t           state_reg, state_next;

  assign full        = (level_reg == LVL_W'(FIFO_DEPTH));
  assign empty       = (level_reg == '0);
  assign tx.tx_ready = !full && !rst;
  assign push        = tx.tx_valid && tx.tx_ready;
  assign pop         = (state_reg == IDLE) && !empty;
  assign fifo_level  = level_reg;

  always_ff @(posedge clk_50M) begin
    if (push) begin
      mem[wr_ptr_reg] <= {tx.tx_dc, tx.tx_data};
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // ---------------- FSM and shifter ----------------
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [HLD_W-1:0] hcnt_reg, hcnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             dc_reg, dc_next;
  logic             done_pre_reg, done_pre_next;
  logic             half_end;

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      hcnt_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      dc_reg       <= 1'b0;
      done_pre_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      hcnt_reg     <= hcnt_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      dc_reg       <= dc_next;
      done_pre_reg <= done_pre_next;
    end
  end

  assign half_end = (cnt_reg == CNT_W'(CLK_DIV - 1));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + CNT_W'(1);
    hcnt_next     = hcnt_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    dc_next       = dc_reg;
    done_pre_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        hcnt_next = '0;
        if (!empty) begin
          state_next            = SETUP;
          {dc_next, shift_next} = mem[rd_ptr_reg];
          bit_next              = '0;
        end
      end
      SETUP: begin
        if (half_end) begin
          state_next = HIGH;
          cnt_next   = '0;
        end
      end
      HIGH: begin
        if (half_end) begin
          cnt_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = HOLD;
          end else begin
            state_next = LOW;
            shift_next = {shift_reg[6:0], 1'b0};
            bit_next   = bit_reg + 3'd1;
          end
        end
      end
      LOW: begin
        if (half_end) begin
          state_next = HIGH;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        cnt_next  = '0;
        hcnt_next = hcnt_reg + HLD_W'(1);
        if (hcnt_reg == HLD_W'(CS_HOLD - 1)) begin
          state_next    = IDLE;
          hcnt_next     = '0;
          done_pre_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  logic ss_next, sclk_next, sdin_next, oled_dc_next, done_next;

  always_comb begin
    ss_next      = (state_reg == IDLE);
    sclk_next    = (state_reg == HIGH);
    sdin_next    = shift_reg[7];
    oled_dc_next = dc_reg;
    done_next    = done_pre_reg;
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      ss        <= 1'b1;
      oled_sclk <= 1'b0;
      oled_sdin <= 1'b0;
      oled_dc   <= 1'b0;
      done      <= 1'b0;
    end else begin
      ss        <= ss_next;
      oled_sclk <= sclk_next;
      oled_sdin <= sdin_next;
      oled_dc   <= oled_dc_next;
      done      <= done_next;
    end
  end

  // done_pre_reg keeps busy high until the registered done pulse appears.
  assign busy = !empty || (state_reg != IDLE) || done_pre_reg;

endmodule

// File: tb/tb_ssd1306_spi_byte_tx.sv
// Scoreboard bench: the driver queues expected {dc,byte}; a pin-level monitor rebuilds each SPI byte and compares.
// A second instance with CLK_DIV=1 covers the fastest clock divider.
module tb_ssd1306_spi_byte_tx;
  localparam int A_LOW = 16 * 4 + 2;

  logic clk_50M = 1'b0;
  logic rst = 1'b1;
  always #5 clk_50M = ~clk_50M;

  ssd1306_spi_byte_tx_if a_if ();
  ssd1306_spi_byte_tx_if b_if ();

  logic [2:0] a_lvl, b_lvl;
  logic a_busy, a_done, a_sclk, a_sdin, a_dc, a_ss;
  logic b_busy, b_done, b_sclk, b_sdin, b_dc, b_ss;

  ssd1306_spi_byte_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .CS_HOLD(2)) u_dut_a (
    .clk_50M(clk_50M), .rst(rst), .tx(a_if.slave), .fifo_level(a_lvl), .busy(a_busy),
    .done(a_done), .oled_sclk(a_sclk), .oled_sdin(a_sdin), .oled_dc(a_dc), .ss(a_ss));

  ssd1306_spi_byte_tx #(.CLK_DIV(1), .FIFO_DEPTH(4), .CS_HOLD(2)) u_dut_b (
    .clk_50M(clk_50M), .rst(rst), .tx(b_if.slave), .fifo_level(b_lvl), .busy(b_busy),
    .done(b_done), .oled_sclk(b_sclk), .oled_sdin(b_sdin), .oled_dc(b_dc), .ss(b_ss));

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];
  int a_done_cnt = 0;
  int a_bytes = 0;
  bit saw_full = 0;
  int lvl_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  bit       prev_ss = 1'b1, prev_sclk = 1'b0, in_byte = 1'b0, ss_rise, dc_first, dc_bad;
  int       low_cnt, nbits;
  logic [7:0] bits;
  logic [8:0] e;

  always @(negedge clk_50M) begin
    if (rst) begin
      in_byte = 1'b0;
    end else begin
      ss_rise = !prev_ss && a_ss && in_byte;
      if (prev_ss && !a_ss) begin
        in_byte = 1'b1; low_cnt = 0; nbits = 0; dc_first = a_dc; dc_bad = 1'b0;
      end
      if (!a_ss) begin
        low_cnt++;
        if (a_sclk && !prev_sclk) begin
          bits = {bits[6:0], a_sdin};
          nbits++;
        end
        if (a_dc !== dc_first) dc_bad = 1'b1;
      end
      if (a_done || ss_rise) check("done_at_ss_rise", a_done, ss_rise);
      if (a_done) a_done_cnt++;
      if (ss_rise) begin
        in_byte = 1'b0;
        a_bytes++;
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("byte_data", bits, e[7:0]);
          check("byte_dc", dc_first, e[8]);
          check("bit_count", nbits, 8);
          check("ss_low_cycles", low_cnt, A_LOW);
          check("dc_stable", dc_bad, 0);
          check("sclk_idle_low", a_sclk, 0);
          $display("byte %0d: data=%02h dc=%0d ss_low=%0d exp=%02h/%0d",
                   a_bytes, bits, dc_first, low_cnt, e[7:0], e[8]);
        end
      end
      if (a_if.tx_valid && !a_if.tx_ready) saw_full = 1'b1;
      if (int'(a_lvl) > lvl_max) lvl_max = int'(a_lvl);
    end
    prev_ss = a_ss;
    prev_sclk = a_sclk;
  end

  // ---------------- driver helpers (all start and end at a negedge) ----------------
  task automatic push(input logic [7:0] d, input logic dcb);
    int t = 0;
    a_if.tx_valid = 1'b1; a_if.tx_data = d; a_if.tx_dc = dcb;
    while (!a_if.tx_ready && t < 2000) begin
      @(negedge clk_50M);
      t++;
    end
    if (t >= 2000) begin
      check("push_timeout", t, 0);
    end else begin
      exp_q.push_back({dcb, d});
      @(negedge clk_50M);
    end
    a_if.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    do begin
      @(negedge clk_50M);
      t++;
    end while ((a_busy || !a_ss) && t < 3000);
    check({name, "_idle_in_time"}, t < 3000, 1);
  endtask

  initial begin
    int t, rises, lowc, tog, dstart;
    logic pb, pc;
    logic [7:0] bb, rv;
    a_if.tx_valid = 1'b0; a_if.tx_data = '0; a_if.tx_dc = 1'b0;
    b_if.tx_valid = 1'b0; b_if.tx_data = '0; b_if.tx_dc = 1'b0;
    repeat (3) @(negedge clk_50M);
    check("rst_ss", a_ss, 1);
    check("rst_sclk", a_sclk, 0);
    check("rst_sdin", a_sdin, 0);
    check("rst_dc", a_dc, 0);
    check("rst_done", a_done, 0);
    check("rst_busy", a_busy, 0);
    check("rst_level", a_lvl, 0);
    check("rst_ready", a_if.tx_ready, 0);
    rst = 1'b0;
    @(negedge clk_50M);
    check("ready_after_rst", a_if.tx_ready, 1);

    // 1: single command byte, latency and busy/done alignment
    push(8'hAF, 1'b0);
    check("busy_after_push", a_busy, 1);
    check("ss_high_c1", a_ss, 1);
    @(negedge clk_50M);
    check("ss_high_c2", a_ss, 1);
    @(negedge clk_50M);
    check("ss_fall_2_after_accept", a_ss, 0);
    t = 0;
    do begin
      pb = a_busy;
      @(negedge clk_50M);
      t++;
    end while (!a_done && t < 200);
    check("t1_done_seen", a_done, 1);
    check("busy_drop_with_done", a_busy, 0);
    check("busy_before_done", pb, 1);

    // 2: display-data byte
    push(8'h81, 1'b1);
    wait_idle("t2");

    // 3: six back-to-back bytes through a 4-deep FIFO
    saw_full = 1'b0; lvl_max = 0; dstart = a_done_cnt;
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), 1'b0);
    wait_idle("t3");
    check("t3_ready_dropped", saw_full, 1);
    check("t3_level_max", lvl_max, 4);
    check("t3_done_pulses", a_done_cnt - dstart, 6);

    // 4: reset during the 4th HIGH phase flushes everything
    push(8'($urandom), 1'b0);
    push(8'($urandom), 1'b1);
    push(8'($urandom), 1'b0);
    rises = 0; t = 0; pc = a_sclk;
    while (rises < 4 && t < 500) begin
      @(negedge clk_50M);
      t++;
      if (a_sclk && !pc) rises++;
      pc = a_sclk;
    end
    check("t4_reach_4th_high", rises, 4);
    rst = 1'b1;
    @(negedge clk_50M);
    check("t4_ss", a_ss, 1);
    check("t4_sclk", a_sclk, 0);
    check("t4_busy", a_busy, 0);
    check("t4_level", a_lvl, 0);
    exp_q.delete();
    @(negedge clk_50M);
    rst = 1'b0;
    lowc = 0;
    repeat (100) begin
      @(negedge clk_50M);
      if (!a_ss) lowc++;
    end
    check("t4_no_resume", lowc, 0);
    push(8'hA5, 1'b1);
    wait_idle("t4");

    // 5: CLK_DIV=1 instance
    b_if.tx_valid = 1'b1; b_if.tx_data = 8'hFF; b_if.tx_dc = 1'b1;
    @(negedge clk_50M);
    b_if.tx_valid = 1'b0;
    t = 0; lowc = 0; tog = 0; rises = 0; pc = b_sclk; bb = '0; pb = 1'b0;
    do begin
      @(negedge clk_50M);
      t++;
      if (!b_ss) begin
        pb = 1'b1;
        lowc++;
        if (b_sclk != pc) tog++;
        if (b_sclk && !pc) begin
          rises++;
          bb = {bb[6:0], b_sdin};
        end
        if (b_dc !== 1'b1) check("t5_dc", b_dc, 1);
      end
      pc = b_sclk;
    end while (!(pb && b_ss) && t < 200);
    $display("div1 byte: data=%02h ss_low=%0d toggles=%0d rises=%0d", bb, lowc, tog, rises);
    check("t5_ss_low", lowc, 18);
    check("t5_toggles", tog, 16);
    check("t5_rises", rises, 8);
    check("t5_data", bb, 8'hFF);
    check("t5_done", b_done, 1);

    // 6: full FIFO with a waiting byte
    for (int i = 0; i < 5; i++) push(8'($urandom), 1'($urandom));
    rv = 8'($urandom);
    a_if.tx_valid = 1'b1; a_if.tx_data = rv; a_if.tx_dc = 1'b0;
    t = 0; lowc = 0;
    while (!a_if.tx_ready && t < 500) begin
      if (a_lvl != 3'd4) lowc++;
      @(negedge clk_50M);
      t++;
    end
    check("t6_ready_rose", a_if.tx_ready, 1);
    check("t6_level_held_full", lowc, 0);
    check("t6_ready_with_done", a_done, 1);
    check("t6_level_after_pop", a_lvl, 3);
    exp_q.push_back({1'b0, rv});
    @(negedge clk_50M);
    a_if.tx_valid = 1'b0;
    wait_idle("t6");

    // 7: random bytes with random gaps
    for (int i = 0; i < 10; i++) begin
      push(8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 80)) @(negedge clk_50M);
    end
    wait_idle("t7");

    repeat (5) @(negedge clk_50M);
    check("exp_q_drained", exp_q.size(), 0);
    check("done_per_byte", a_done_cnt, a_bytes);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
